wb_bram_ctrl: RTL and testbench

//  Wishbone classic slave fronting the user-project BRAM (mprjram), mapped at 0x3800_0000.

---
 rtl/wb_bram_pkg.sv | 17 +
 rtl/bram_sp.sv | 43 ++++
 rtl/wb_bram_ctrl.sv | 176 +++++++++++++++++
 tb/tb_wb_bram_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_pkg.sv
// -----------------------------------------------------------------------------
// wb_bram_pkg
// Shared definitions for the Wishbone BRAM controller:
//   state_e       - controller FSM state encoding (IDLE / WAIT / ACK)
//   ADDR_BASE_HI  - top address byte of the BRAM window (0x38 -> 0x3800_0000)
// -----------------------------------------------------------------------------
package wb_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [7:0] ADDR_BASE_HI = 8'h38;

endpackage

// File: rtl/bram_sp.sv
// -----------------------------------------------------------------------------
// bram_sp
// Single-port DEPTH_WORDS x 32 memory with per-byte write enables and a
// one-cycle registered read.
// Ports:
//   clk      in   clock
//   rd_en_i  in   read enable; rdata_o updates on the next edge
//   be_i     in   byte write enables; bit n writes wdata_i[8n+7:8n]
//   addr_i   in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data (holds until the next read)
// -----------------------------------------------------------------------------
module bram_sp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // NOTE: the memory array has no reset on purpose; a reset loop over every
    // word would stop the tools from mapping it onto a block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_bram_ctrl
// Wishbone classic slave for the user-project BRAM window at ADDR_BASE.
// Decodes the window, waits DELAYS cycles, then performs a byte-lane write or
// registered read on bram_sp and returns a single-cycle acknowledge.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i, wbs_stb_i        bus cycle / strobe
//   wbs_we_i, wbs_sel_i         direction, byte-lane enables
//   wbs_adr_i, wbs_dat_i        byte address, write data
//   wbs_ack_o, wbs_dat_o        acknowledge, read data (zero outside read acks)
// Optional (macro WB_BRAM_STATS_EN defined):
//   stat_rd_cnt, stat_wr_cnt    saturating counts of acked reads / writes
// -----------------------------------------------------------------------------
module wb_bram_ctrl
    import wb_bram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = {ADDR_BASE_HI, 24'h00_0000},
    parameter int          DEPTH_WORDS = 1024,
    parameter int          DELAYS      = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
`ifdef WB_BRAM_STATS_EN
    ,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(DELAYS + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               we_q,    we_d;
    logic [3:0]         sel_q,   sel_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [31:0]        dat_q,   dat_d;

    logic               req;
    logic               hit;
    logic               mem_rd_en;
    logic [3:0]         mem_be;
    logic [31:0]        mem_rdata;
    logic               unused_adr;

    assign req = wbs_cyc_i & wbs_stb_i;
    assign hit = req & (wbs_adr_i[31:24] == ADDR_BASE[31:24]);

    // Only the window byte and the word index matter; the rest alias.
    assign unused_adr = ^wbs_adr_i;

    // NOTE: every always_comb output gets a default first so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        dat_d     = dat_q;
        mem_rd_en = 1'b0;
        mem_be    = 4'h0;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(DELAYS);
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    idx_d   = wbs_adr_i[2 +: IDX_W];
                    dat_d   = wbs_dat_i;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    // Master gave up: drop the request without an ack.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    // Access was issued last cycle; read data is now registered.
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        mem_rd_en = ~we_q & ~wb_rst_i;
                        mem_be    = (we_q & ~wb_rst_i) ? sel_q : 4'h0;
                    end
                end
            end
            ST_ACK: begin
                // Return to IDLE unconditionally so a held request is not re-accepted.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its _d input regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            idx_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
        end
    end

    bram_sp #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bram (
        .clk     (wb_clk_i),
        .rd_en_i (mem_rd_en),
        .be_i    (mem_be),
        .addr_i  (idx_q),
        .wdata_i (dat_q),
        .rdata_o (mem_rdata)
    );

    assign wbs_ack_o = (state_q == ST_ACK);
    assign wbs_dat_o = (state_q == ST_ACK && !we_q) ? mem_rdata : 32'h0;

`ifdef WB_BRAM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_q == ST_ACK) begin
            if (!we_q && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            if ( we_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_cnt_q <= 16'h0;
            wr_cnt_q <= 16'h0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
`else
    // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_bram_ctrl
// Self-checking bench for wb_bram_ctrl (DEPTH_WORDS = 1024, DELAYS = 10).
// Directed scenarios followed by randomized traffic compared against a
// word-array model of the BRAM with byte-lane merge and address aliasing.
// -----------------------------------------------------------------------------
module tb_wb_bram_ctrl;

    localparam int DEPTH  = 1024;
    localparam int DELAYS = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
`ifdef WB_BRAM_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

    always #5 clk = ~clk;

    wb_bram_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .DELAYS      (DELAYS)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_i),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o)
`ifdef WB_BRAM_STATS_EN
        ,
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;
    int exp_rd     = 0;
    int exp_wr     = 0;

    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Drive one request and wait (bounded) for its ack. With hold set, the
    // request stays asserted one cycle beyond the ack cycle.
    task automatic bus_op(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input bit hold,
                          output bit acked, output int lat, output logic [31:0] rd);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_i = d;
        acked = 1'b0; lat = -1; rd = 32'h0;
        for (int n = 0; n < 40 && !acked; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) begin
                acked = 1'b1;
                lat   = n;
                rd    = dat_o;
            end
        end
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Count acks over a window with the bus idle (or request as currently driven).
    task automatic count_acks(input int cycles, output int n_ack);
        n_ack = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        bit acked; int lat; logic [31:0] rd;
        bus_op(1'b1, a, s, d, 1'b0, acked, lat, rd);
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(DELAYS + 1));
        check({tag, "_dat0"}, rd, 32'h0);
        if (acked) begin
            exp_wr++;
            for (int b = 0; b < 4; b++)
                if (s[b]) model[word_of(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        bit acked; int lat; logic [31:0] rd;
        bus_op(1'b0, a, 4'h0, 32'h0, 1'b0, acked, lat, rd);
        check({tag, "_ack"}, 32'(acked), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(DELAYS + 1));
        check({tag, "_data"}, rd, model[word_of(a)]);
        if (acked) exp_rd++;
    endtask

    task automatic no_hit(input string tag, input logic [31:0] a, input int cycles);
        int n_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
        count_acks(cycles, n_ack);
        cyc = 1'b0; stb = 1'b0;
        check({tag, "_noack"}, 32'(n_ack), 32'd0);
    endtask

    initial begin
        bit          acked;
        int          lat, n_ack;
        logic [31:0] rd, a, d;
        logic [3:0]  s;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; dat_i = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'h0);
        rst = 1'b0;

        // 1. Full write then read back.
        do_write("t1_wr", 32'h3800_0000, 4'hF, 32'h1234_5678);
        do_read ("t1_rd", 32'h3800_0000);
        check("t1_value", model[0], 32'h1234_5678);

        // 2. Single-lane write merges into the existing word.
        do_write("t2_wr", 32'h3800_0000, 4'b0010, 32'h0000_AB00);
        do_read ("t2_rd", 32'h3800_0000);
        check("t2_value", model[0], 32'h1234_AB78);

        // 3. Out-of-window request is never acknowledged.
        no_hit("t3", 32'h3000_0000, 30);

        // 4. Aliasing: 0x3800_1000 maps to word 0.
        do_write("t4_wr", 32'h3800_1000, 4'hF, 32'hDEAD_BEEF);
        do_read ("t4_rd", 32'h3800_0000);

        // 5. Aborted write leaves memory untouched.
        do_write("t5_pre", 32'h3800_0004, 4'hF, 32'h5555_0004);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
        adr = 32'h3800_0004; dat_i = 32'hFFFF_FFFF;
        n_ack = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        cyc = 1'b0;
        count_acks(20, lat);
        stb = 1'b0; we = 1'b0;
        check("t5_noack", 32'(n_ack + lat), 32'd0);
        do_read("t5_rd", 32'h3800_0004);

        // Request held through the ack cycle is not re-accepted.
        bus_op(1'b0, 32'h3800_0004, 4'h0, 32'h0, 1'b1, acked, lat, rd);
        check("b2b_first", 32'(acked), 32'd1);
        if (acked) exp_rd++;
        count_acks(20, n_ack);
        check("b2b_noreack", 32'(n_ack), 32'd0);

`ifdef WB_BRAM_STATS_EN
        check("stat_rd_pre", 32'(stat_rd_cnt), 32'(exp_rd));
        check("stat_wr_pre", 32'(stat_wr_cnt), 32'(exp_wr));
`endif

        // 6. Reset in the middle of a pending read.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3800_0000;
        repeat (5) @(negedge clk);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        check("t6_rst_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        exp_rd = 0; exp_wr = 0;
        count_acks(20, n_ack);
        check("t6_noack", 32'(n_ack), 32'd0);
        do_read("t6_rd", 32'h3800_0000);
`ifdef WB_BRAM_STATS_EN
        check("t6_stat_rd", 32'(stat_rd_cnt), 32'd1);
`endif

        // Randomized traffic over a small set of words, seeded with full writes.
        for (int i = 8; i < 16; i++)
            do_write("seed_wr", 32'h3800_0000 | (32'(i) << 2), 4'hF, $urandom);

        for (int k = 0; k < 40; k++) begin
            a = 32'h3800_0000 | (($urandom & 32'hFFF) << 12)
                | (32'($urandom_range(8, 15)) << 2) | ($urandom & 32'h3);
            case ($urandom_range(0, 9))
                0: begin
                    a[31:24] = 8'($urandom_range(0, 255));
                    if (a[31:24] == 8'h38) a[31:24] = 8'h30;
                    no_hit("rnd_nohit", a, 14);
                end
                1, 2, 3, 4: begin
                    s = 4'($urandom);
                    d = $urandom;
                    do_write("rnd_wr", a, s, d);
                end
                default: do_read("rnd_rd", a);
            endcase
        end

`ifdef WB_BRAM_STATS_EN
        @(negedge clk);
        check("stat_rd_end", 32'(stat_rd_cnt), 32'(exp_rd));
        check("stat_wr_end", 32'(stat_wr_cnt), 32'(exp_wr));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
